// File: rtl/gpu_mem_fifo_drain.sv
// Drains the pixel-write FIFO and coalesces same-block entries into masked VRAM bursts.
// Define GPU_MEM_DRAIN_STATS_EN to add burst/word statistics counters.
module gpu_mem_fifo_drain #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 19,
  parameter int BURST_W   = 3,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 15,
  parameter int TIMEOUT_W = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_W+DATA_W-1:0]      fifo_data_i,
  input  logic                          fifo_valid_i,
  output logic                          fifo_pop_o,
  input  logic                          flush_i,
  output logic                          mem_req_o,
  input  logic                          mem_ack_i,
  output logic [ADDR_W-BURST_W-1:0]     mem_addr_o,
  output logic [BURST_LEN*DATA_W-1:0]   mem_wdata_o,
  output logic [BURST_LEN-1:0]          mem_mask_o,
  output logic                          idle_o
`ifdef GPU_MEM_DRAIN_STATS_EN
  ,
  output logic [31:0]                   stat_bursts_o,
  output logic [31:0]                   stat_words_o
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GATHER = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;

  logic [1:0]                  state;
  logic [TIMEOUT_W-1:0]        tmo;
  logic [ADDR_W-BURST_W-1:0]   blk;
  logic [BURST_W-1:0]          slot;
  logic [DATA_W-1:0]           pix;
  logic                        force_out;
  logic                        same_blk;

  assign blk       = fifo_data_i[ADDR_W+DATA_W-1:DATA_W+BURST_W];
  assign slot      = fifo_data_i[DATA_W+BURST_W-1:DATA_W];
  assign pix       = fifo_data_i[DATA_W-1:0];
  assign force_out = flush_i | (&mem_mask_o) | (tmo == TIMEOUT_W'(TIMEOUT));
  assign same_blk  = (blk == mem_addr_o);
  assign mem_req_o = (state == S_ISSUE);
  assign idle_o    = (state == S_IDLE) && !fifo_valid_i;

  always_comb begin
    fifo_pop_o = 1'b0;
    case (state)
      S_IDLE:   fifo_pop_o = fifo_valid_i;
      S_GATHER: fifo_pop_o = !force_out && fifo_valid_i && same_blk;
      default:  fifo_pop_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      tmo         <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_mask_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // data/mask are already zero here, so only the popped slot is written
          if (fifo_valid_i) begin
            mem_addr_o                        <= blk;
            mem_wdata_o[slot*DATA_W +: DATA_W] <= pix;
            mem_mask_o                        <= BURST_LEN'(1) << slot;
            tmo                               <= '0;
            state                             <= S_GATHER;
          end
        end
        S_GATHER: begin
          if (force_out) begin
            state <= S_ISSUE;
          end else if (fifo_valid_i && same_blk) begin
            mem_wdata_o[slot*DATA_W +: DATA_W] <= pix;
            mem_mask_o[slot]                   <= 1'b1;
            tmo                                <= '0;
          end else if (fifo_valid_i) begin
            state <= S_ISSUE;
          end else if (tmo != TIMEOUT_W'(TIMEOUT)) begin
            tmo <= tmo + 1'b1;
          end
        end
        S_ISSUE: begin
          if (mem_ack_i) begin
            mem_wdata_o <= '0;
            mem_mask_o  <= '0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GPU_MEM_DRAIN_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_bursts_o <= '0;
      stat_words_o  <= '0;
    end else if (state == S_ISSUE && mem_ack_i) begin
      stat_bursts_o <= stat_bursts_o + 32'd1;
      stat_words_o  <= stat_words_o + 32'($countones(mem_mask_o));
    end
  end
`endif

endmodule

// File: tb/tb_gpu_mem_fifo_drain.sv
// Bench for gpu_mem_fifo_drain: queue-backed FIFO, burst-level model, directed scenarios.
module tb_gpu_mem_fifo_drain;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [34:0]  fifo_data;
  logic         fifo_valid, fifo_pop, flush, mem_req, mem_ack, idle;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [7:0]   mem_mask;
`ifdef GPU_MEM_DRAIN_STATS_EN
  logic [31:0]  stat_bursts, stat_words;
`endif

  gpu_mem_fifo_drain dut (
    .clk_i(clk), .rst_i(rst), .fifo_data_i(fifo_data), .fifo_valid_i(fifo_valid),
    .fifo_pop_o(fifo_pop), .flush_i(flush), .mem_req_o(mem_req), .mem_ack_i(mem_ack),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_mask_o(mem_mask), .idle_o(idle)
`ifdef GPU_MEM_DRAIN_STATS_EN
    , .stat_bursts_o(stat_bursts), .stat_words_o(stat_words)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [34:0] fq[$];

  // model: the burst being built, and whether it is waiting on the arbiter
  bit          m_have, m_send;
  logic [15:0] m_blk;
  logic [15:0] m_data[8];
  bit          m_mask[8];
  int          m_quiet;

  logic [15:0]  l_addr;
  logic [7:0]   l_mask;
  logic [127:0] l_wdata;
  int nb = 0, pops = 0, reqc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_valid = (fq.size() != 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [18:0] a, input logic [15:0] p);
    fq.push_back({a, p});
    refresh();
  endtask

  task automatic model_reset();
    m_have = 0; m_send = 0; m_blk = '0; m_quiet = 0;
    for (int i = 0; i < 8; i++) begin m_data[i] = '0; m_mask[i] = 0; end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < 8; i++) if (!m_mask[i]) return 0;
    return 1;
  endfunction

  function automatic bit exp_pop();
    if (!fifo_valid || m_send) return 0;
    if (!m_have) return 1;
    if (flush || m_full() || m_quiet == 15) return 0;
    return fifo_data[34:19] == m_blk;
  endfunction

  function automatic logic [7:0] exp_mask();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m_mask[i];
    return r;
  endfunction

  function automatic logic [127:0] exp_wdata();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = m_data[i];
    return r;
  endfunction

  task automatic model_step();
    bit p;
    int s;
    p = exp_pop();
    s = int'(fifo_data[18:16]);
    if (rst) model_reset();
    else if (m_send) begin
      if (mem_ack) begin
        m_have = 0; m_send = 0; m_quiet = 0;
        for (int i = 0; i < 8; i++) begin m_data[i] = '0; m_mask[i] = 0; end
      end
    end else if (!m_have) begin
      if (p) begin
        m_have = 1; m_blk = fifo_data[34:19]; m_quiet = 0;
        m_data[s] = fifo_data[15:0]; m_mask[s] = 1;
      end
    end else if (flush || m_full() || m_quiet == 15) m_send = 1;
    else if (p) begin
      m_data[s] = fifo_data[15:0]; m_mask[s] = 1; m_quiet = 0;
    end else if (fifo_valid) m_send = 1;
    else if (m_quiet < 15) m_quiet++;
  endtask

  // one clock: compare at negedge, advance model at posedge, update FIFO just after
  task automatic cycle();
    bit dpop;
    @(negedge clk);
    chk("pop",   fifo_pop,  exp_pop());
    chk("req",   mem_req,   m_send);
    chk("idle",  idle,      !m_have && !fifo_valid);
    chk("addr",  mem_addr,  m_blk);
    chk("mask",  mem_mask,  exp_mask());
    chk("wdata", mem_wdata, exp_wdata());
    dpop = fifo_pop;
    if (dpop) pops++;
    if (mem_req) reqc++;
    if (mem_req && mem_ack) begin
      l_addr = mem_addr; l_mask = mem_mask; l_wdata = mem_wdata; nb++;
    end
    @(posedge clk);
    model_step();
    #1;
    if (dpop && !rst && fq.size() != 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic run_burst(input int maxc, output int cyc);
    int n0;
    n0 = nb; cyc = 0;
    while (nb == n0 && cyc < maxc) begin cycle(); cyc++; end
    chk("burst_seen", nb != n0, 1'b1);
  endtask

  int cyc, r0;
  logic [127:0] w;

  initial begin
    flush = 0; mem_ack = 0;
    model_reset();
    refresh();
    cycle(); cycle();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_mask", mem_mask, 8'h0);
    chk("rst_wdata", mem_wdata, 128'h0);
    chk("rst_idle", idle, 1'b1);
    rst = 0;
    cycle();

    // full burst, immediate ack
    mem_ack = 1; pops = 0;
    for (int i = 0; i < 8; i++) push(19'(i), 16'(16'h1000 + i));
    run_burst(40, cyc);
    w = '0;
    for (int i = 0; i < 8; i++) w[i*16 +: 16] = 16'(16'h1000 + i);
    chk("t1_addr", l_addr, 16'h0);
    chk("t1_mask", l_mask, 8'hFF);
    chk("t1_wdata", l_wdata, w);
    chk("t1_pops", pops, 8);
    chk("t1_cycles", cyc, 10);
    cycle();

    // partial burst forced out by timeout
    push(19'h10, 16'hAAAA); push(19'h13, 16'hBBBB);
    run_burst(40, cyc);
    w = '0; w[15:0] = 16'hAAAA; w[63:48] = 16'hBBBB;
    chk("t2_addr", l_addr, 16'h2);
    chk("t2_mask", l_mask, 8'h09);
    chk("t2_wdata", l_wdata, w);
    chk("t2_cycles", cyc, 19);
    cycle();

    // block change ends burst; arbiter stalls 25 cycles
    mem_ack = 0; pops = 0; reqc = 0;
    push(19'h21, 16'h0021); push(19'h30, 16'h0030);
    for (int i = 0; i < 25; i++) cycle();
    chk("t3_pops", pops, 1);
    chk("t3_reqc", reqc, 23);
    chk("t3_fifo_left", fq.size(), 1);
    mem_ack = 1;
    run_burst(5, cyc);
    w = '0; w[31:16] = 16'h0021;
    chk("t3a_addr", l_addr, 16'h4);
    chk("t3a_mask", l_mask, 8'h02);
    chk("t3a_wdata", l_wdata, w);
    run_burst(40, cyc);
    w = '0; w[15:0] = 16'h0030;
    chk("t3b_addr", l_addr, 16'h6);
    chk("t3b_mask", l_mask, 8'h01);
    chk("t3b_wdata", l_wdata, w);
    cycle();

    // same slot twice, then flush
    push(19'h05, 16'h1111); push(19'h05, 16'h2222);
    cycle(); cycle();
    flush = 1; cycle(); flush = 0;
    run_burst(10, cyc);
    w = '0; w[95:80] = 16'h2222;
    chk("t4_addr", l_addr, 16'h0);
    chk("t4_mask", l_mask, 8'h20);
    chk("t4_wdata", l_wdata, w);
    cycle(); cycle();
    r0 = reqc;
    flush = 1;
    for (int i = 0; i < 5; i++) cycle();
    flush = 0;
    chk("t4_idle_flush_reqs", reqc - r0, 0);

    // async reset while a burst waits on the arbiter
    mem_ack = 0; r0 = reqc;
    for (int i = 0; i < 8; i++) push(19'(8'h40 + i), 16'(16'h4000 + i));
    cyc = 0;
    while (reqc == r0 && cyc < 30) begin cycle(); cyc++; end
    chk("t6_req_reached", reqc != r0, 1'b1);
    #2 rst = 1;
    model_reset();
    #1;
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_mask", mem_mask, 8'h0);
    chk("t6_rst_addr", mem_addr, 16'h0);
    cycle(); cycle();
    rst = 0;
    mem_ack = 1;
    push(19'h51, 16'h5151);
    cycle();
    flush = 1; cycle(); flush = 0;
    run_burst(10, cyc);
    w = '0; w[31:16] = 16'h5151;
    chk("t6_addr", l_addr, 16'hA);
    chk("t6_mask", l_mask, 8'h02);
    chk("t6_wdata", l_wdata, w);
    cycle();

    // fresh reset, then one full and one single-word burst
    rst = 1; model_reset();
    cycle(); rst = 0;
`ifdef GPU_MEM_DRAIN_STATS_EN
    chk("stat_bursts_rst", stat_bursts, 32'd0);
    chk("stat_words_rst", stat_words, 32'd0);
`endif
    for (int i = 0; i < 8; i++) push(19'(i), 16'(16'h7000 + i));
    run_burst(40, cyc);
    chk("t7a_mask", l_mask, 8'hFF);
    cycle();
    push(19'h08, 16'h7777);
    cycle();
    flush = 1; cycle(); flush = 0;
    run_burst(10, cyc);
    chk("t7b_addr", l_addr, 16'h1);
    chk("t7b_mask", l_mask, 8'h01);
    cycle();
`ifdef GPU_MEM_DRAIN_STATS_EN
    chk("stat_bursts", stat_bursts, 32'd2);
    chk("stat_words", stat_words, 32'd9);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/gpu_mem_fifo_drain.md
Name: gpu_mem_fifo_drain

Overview:
Read-side companion to the GPU memory write FIFO. Pops {address, pixel} entries from a valid/pop FIFO output and coalesces entries that fall in the same aligned VRAM block into one masked burst. Issues each burst to the memory arbiter over a req/ack handshake. Sits between the pixel-write FIFO and the VRAM memory controller port.

Parameters:
DATA_W, 16, width of one pixel word
ADDR_W, 19, word address width of a FIFO entry
BURST_W, 3, log2 of burst length
BURST_LEN, 8, words per burst (must equal 2**BURST_W)
TIMEOUT, 15, idle cycles in GATHER before a partial burst is forced out (1..2**TIMEOUT_W-1)
TIMEOUT_W, 4, timeout counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
fifo_data_i  in  ADDR_W+DATA_W  FIFO head entry: [ADDR_W+DATA_W-1:DATA_W]=word address, [DATA_W-1:0]=pixel
fifo_valid_i  in  1  FIFO non-empty
fifo_pop_o  out  1  pop head this cycle (combinational)
flush_i  in  1  force out the partial burst
mem_req_o  out  1  burst request
mem_ack_i  in  1  arbiter accepts burst
mem_addr_o  out  ADDR_W-BURST_W  block address (addr[ADDR_W-1:BURST_W])
mem_wdata_o  out  BURST_LEN*DATA_W  slot i at [i*DATA_W +: DATA_W]
mem_mask_o  out  BURST_LEN  per-slot write enable
idle_o  out  1  state IDLE and fifo_valid_i low

Behaviour:
- Reset (async, immediate): state IDLE, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, mem_mask_o=0, timeout count=0. Any pending/in-flight burst is dropped; mem_req_o falls without waiting for ack.
- Entry split: blk = addr[ADDR_W-1:BURST_W], slot = addr[BURST_W-1:0].
- IDLE: fifo_pop_o = fifo_valid_i. On pop: latch blk into mem_addr_o, write pixel to slot, mask = one-hot(slot), clear timeout, go GATHER.
- GATHER, priority order:
  1. flush_i=1 or mask all-ones or timeout==TIMEOUT: no pop, go ISSUE next cycle.
  2. fifo_valid_i=1 and blk==mem_addr_o: pop, write slot, set mask bit, clear timeout. Same slot hit twice: later data overwrites earlier.
  3. fifo_valid_i=1 and blk!=mem_addr_o: no pop, go ISSUE (entry stays in FIFO).
  4. fifo_valid_i=0: timeout += 1 (saturate at TIMEOUT).
- ISSUE: mem_req_o=1. mem_addr_o/mem_wdata_o/mem_mask_o stable until ack. fifo_pop_o=0. mem_ack_i may be high in the first ISSUE cycle. On ack: next cycle IDLE, mask cleared, data cleared to 0, mem_req_o=0. No back-to-back req without an IDLE cycle.
- Throughput: max 1 pop/cycle. Full 8-word burst costs 8 GATHER/IDLE pops + 1 cycle + arbiter wait.
- Unwritten slots carry data 0 with mask bit 0.
- flush_i is ignored in IDLE and ISSUE.
- Timeout counts consecutive GATHER cycles with fifo_valid_i low. Any pop resets it.

Optional Feature:
GPU_MEM_DRAIN_STATS_EN:
- Defined: adds outputs stat_bursts_o[31:0] (+1 per acked burst) and stat_words_o[31:0] (+popcount(mem_mask_o) per acked burst). Both wrap modulo 2**32, reset to 0, and add no latency to the datapath.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Push addrs 0x00..0x07 (pix 0x1000+i) back-to-back, ack immediate → single req: mem_addr_o=0, mask=0xFF, wdata slot i=0x1000+i; 8 pops then 1 ISSUE cycle.
- Push addr 0x10 (0xAAAA), 0x13 (0xBBBB), then FIFO empty → after 15 idle cycles req: addr=0x2, mask=0x09, slots 0/3 = 0xAAAA/0xBBBB, others 0.
- Push 0x21 then 0x30 → first burst addr=0x4 mask=0x02, no pop of 0x30 until after ack; second burst addr=0x6 mask=0x01.
- Push 0x05 (0x1111) then 0x05 (0x2222), flush_i pulse → addr=0x0 mask=0x20 slot5=0x2222; flush in IDLE → no req.
- Hold mem_ack_i low 20 cycles with FIFO non-empty → mem_req_o/addr/data/mask stable, fifo_pop_o=0 throughout.
- Assert rst_i mid-ISSUE (asynchronously, between edges) → mem_req_o=0 and mask=0 immediately. After release, next entry starts a fresh burst. With GPU_MEM_DRAIN_STATS_EN, stats read 0 after reset and 2/9 after bursts mask=0xFF and 0x01.
